fetch_exec_controller: RTL and testbench

Sequences the instruction-fetch stage and the rest of the pipeline: loads program words into instruction memory, then runs, single-steps, pauses and halts execution. It drives the PC enable and pipeline enable, injects NOP bubbles while draining, and issues a pipeline restart pulse. It sits between the debug/command front end and the IF stage, and takes a stall input from the hazard unit.

---
 rtl/fetch_exec_controller.sv | 184 ++++++++++++++++++
 tb/tb_fetch_exec_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_controller.sv
// Fetch/execute sequencer: loads program words into instruction memory and
// controls run, single-step, pause, halt-drain and restart of the pipeline.
module fetch_exec_controller #(
  parameter int                  NB_INSTR     = 32,
  parameter int                  NB_ADDR      = 10,
  parameter int                  IMEM_DEPTH   = 1024,
  parameter logic [NB_INSTR-1:0] HALT_OPCODE  = 32'hFFFF_FFFF,
  parameter int                  DRAIN_CYCLES = 5,
  parameter int                  NB_CNT       = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [2:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic [NB_INSTR-1:0] i_load_data,
  input  logic                i_load_valid,
  input  logic                i_load_last,
  output logic                o_load_ready,
  output logic                o_imem_we,
  output logic [NB_ADDR-1:0]  o_imem_addr,
  output logic [NB_INSTR-1:0] o_imem_data,
  input  logic [NB_INSTR-1:0] i_instruction,
  input  logic                i_stall,
  output logic                o_pc_enable,
  output logic                o_pipe_enable,
  output logic                o_inject_nop,
  output logic                o_pipe_reset,
  output logic                o_halted,
  output logic [NB_CNT-1:0]   o_cycle_count,
  output logic [2:0]          o_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_PAUSED = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_RUN     = 3'd2;
  localparam logic [2:0] CMD_STEP    = 3'd3;
  localparam logic [2:0] CMD_PAUSE   = 3'd4;
  localparam logic [2:0] CMD_RESTART = 3'd5;

  localparam int                  NB_DRAIN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_INIT = NB_DRAIN'(DRAIN_CYCLES - 1);
  localparam logic [NB_ADDR-1:0]  LAST_ADDR  = NB_ADDR'(IMEM_DEPTH - 1);

  logic [2:0]          state_q, state_d;
  logic [NB_ADDR-1:0]  loadAddr_q, loadAddr_d;
  logic [NB_DRAIN-1:0] drainCnt_q, drainCnt_d;
  logic                imemWe_q, imemWe_d;
  logic [NB_ADDR-1:0]  imemAddr_q, imemAddr_d;
  logic [NB_INSTR-1:0] imemData_q, imemData_d;
  logic                pipeReset_q, pipeReset_d;
  logic [NB_CNT-1:0]   cycleCount_q;
  logic                cntClear;

  logic execState;
  logic haltHit;
  logic cmdReady;
  logic cmdFire;
  logic pipeEnable;
  logic loadBeat;
  logic loadEnd;

  assign execState  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign haltHit    = execState && (i_instruction == HALT_OPCODE);
  assign cmdReady   = (state_q == ST_IDLE) || (state_q == ST_PAUSED) ||
                      (state_q == ST_HALTED) || (state_q == ST_RUN);
  assign cmdFire    = i_cmd_valid && cmdReady;
  assign pipeEnable = execState || (state_q == ST_DRAIN);
  assign loadBeat   = (state_q == ST_LOAD) && i_load_valid;
  assign loadEnd    = loadBeat && (i_load_last || (loadAddr_q == LAST_ADDR));

  // A halt seen while executing wins over PAUSE and over the STEP exit.
  always_comb begin
    state_d     = state_q;
    loadAddr_d  = loadAddr_q;
    drainCnt_d  = drainCnt_q;
    imemWe_d    = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemData_d  = imemData_q;
    pipeReset_d = 1'b0;
    cntClear    = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSED, ST_HALTED: begin
        if (cmdFire) begin
          case (i_cmd)
            CMD_LOAD: begin
              state_d    = ST_LOAD;
              loadAddr_d = '0;
              cntClear   = 1'b1;
            end
            CMD_RESTART: begin
              state_d     = ST_IDLE;
              pipeReset_d = 1'b1;
              cntClear    = 1'b1;
            end
            CMD_RUN:  if (state_q != ST_HALTED) state_d = ST_RUN;
            CMD_STEP: if (state_q != ST_HALTED) state_d = ST_STEP;
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (loadBeat) begin
          imemWe_d   = 1'b1;
          imemAddr_d = loadAddr_q;
          imemData_d = i_load_data;
          loadAddr_d = loadAddr_q + NB_ADDR'(1);
          if (loadEnd) begin
            state_d     = ST_IDLE;
            pipeReset_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (haltHit) begin
          state_d    = ST_DRAIN;
          drainCnt_d = DRAIN_INIT;
        end else if (cmdFire && (i_cmd == CMD_PAUSE)) begin
          state_d = ST_PAUSED;
        end
      end
      ST_STEP: begin
        if (haltHit) begin
          state_d    = ST_DRAIN;
          drainCnt_d = DRAIN_INIT;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_DRAIN: begin
        if (drainCnt_q == '0) state_d = ST_HALTED;
        else                  drainCnt_d = drainCnt_q - NB_DRAIN'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      loadAddr_q  <= '0;
      drainCnt_q  <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemData_q  <= '0;
      pipeReset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      loadAddr_q  <= loadAddr_d;
      drainCnt_q  <= drainCnt_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemData_q  <= imemData_d;
      pipeReset_q <= pipeReset_d;
    end
  end

  // Saturating count of cycles in which the pipeline advanced.
  always_ff @(posedge i_clock) begin
    if (i_reset || cntClear)                   cycleCount_q <= '0;
    else if (pipeEnable && (~cycleCount_q != '0)) cycleCount_q <= cycleCount_q + NB_CNT'(1);
  end

  assign o_cmd_ready   = cmdReady;
  assign o_load_ready  = (state_q == ST_LOAD);
  assign o_imem_we     = imemWe_q;
  assign o_imem_addr   = imemAddr_q;
  assign o_imem_data   = imemData_q;
  assign o_pc_enable   = execState && !i_stall && !haltHit;
  assign o_pipe_enable = pipeEnable;
  assign o_inject_nop  = (state_q == ST_DRAIN) || haltHit;
  assign o_pipe_reset  = pipeReset_q;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycle_count = cycleCount_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Bench for fetch_exec_controller: scoreboarded memory writes on two instances
// (full depth and a 4-word memory) plus per-scenario control checks.
module tb_fetch_exec_controller;

  localparam logic [2:0] CMD_NOP = 3'd0, CMD_LOAD = 3'd1, CMD_RUN = 3'd2, CMD_STEP = 3'd3;
  localparam logic [2:0] CMD_PAUSE = 3'd4, CMD_RESTART = 3'd5;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3;
  localparam logic [2:0] S_PAUSED = 3'd4, S_DRAIN = 3'd5, S_HALTED = 3'd6;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        isLast;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0, cmdValid2 = 1'b0;
  logic [2:0]  cmd = CMD_NOP;
  logic [31:0] loadData = '0;
  logic        loadValid = 1'b0, loadLast = 1'b0;
  logic        loadValid2 = 1'b0, loadLast2 = 1'b0;
  logic [31:0] instruction = '0;
  logic        stall = 1'b0;

  logic        cmdReady1, loadReady1, imemWe1, pcEnable1, pipeEnable1, injectNop1, pipeReset1, halted1;
  logic [9:0]  imemAddr1;
  logic [31:0] imemData1, cycleCount1;
  logic [2:0]  state1;
  logic        cmdReady2, loadReady2, imemWe2, pcEnable2, pipeEnable2, injectNop2, pipeReset2, halted2;
  logic [9:0]  imemAddr2;
  logic [31:0] imemData2, cycleCount2;
  logic [2:0]  state2;

  int  vectors = 0;
  int  miscompares = 0;
  wr_t expQ1[$];
  wr_t expQ2[$];
  wr_t got1, exp1, got2, exp2;

  always #5 clock = ~clock;

  fetch_exec_controller dut (
    .i_clock(clock), .i_reset(reset), .i_cmd_valid(cmdValid), .i_cmd(cmd), .o_cmd_ready(cmdReady1),
    .i_load_data(loadData), .i_load_valid(loadValid), .i_load_last(loadLast), .o_load_ready(loadReady1),
    .o_imem_we(imemWe1), .o_imem_addr(imemAddr1), .o_imem_data(imemData1),
    .i_instruction(instruction), .i_stall(stall), .o_pc_enable(pcEnable1), .o_pipe_enable(pipeEnable1),
    .o_inject_nop(injectNop1), .o_pipe_reset(pipeReset1), .o_halted(halted1),
    .o_cycle_count(cycleCount1), .o_state(state1)
  );

  fetch_exec_controller #(.IMEM_DEPTH(4)) dutSmall (
    .i_clock(clock), .i_reset(reset), .i_cmd_valid(cmdValid2), .i_cmd(cmd), .o_cmd_ready(cmdReady2),
    .i_load_data(loadData), .i_load_valid(loadValid2), .i_load_last(loadLast2), .o_load_ready(loadReady2),
    .o_imem_we(imemWe2), .o_imem_addr(imemAddr2), .o_imem_data(imemData2),
    .i_instruction(instruction), .i_stall(stall), .o_pc_enable(pcEnable2), .o_pipe_enable(pipeEnable2),
    .o_inject_nop(injectNop2), .o_pipe_reset(pipeReset2), .o_halted(halted2),
    .o_cycle_count(cycleCount2), .o_state(state2)
  );

  // Every write is matched against the oldest expected beat; the final beat
  // must carry the pipeline-reset pulse in the same cycle.
  always @(negedge clock) begin
    if (imemWe1 === 1'b1) begin
      vectors++;
      got1 = '{addr: imemAddr1, data: imemData1, isLast: pipeReset1};
      if (expQ1.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL dut_write: got unexpected write addr %0d data %h, required no write", imemAddr1, imemData1);
      end else begin
        exp1 = expQ1.pop_front();
        if (got1 !== exp1) begin
          miscompares++;
          $display("[TB] FAIL dut_write: got addr %0d data %h pipe_reset %b, required addr %0d data %h pipe_reset %b",
                   got1.addr, got1.data, got1.isLast, exp1.addr, exp1.data, exp1.isLast);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (imemWe2 === 1'b1) begin
      vectors++;
      got2 = '{addr: imemAddr2, data: imemData2, isLast: pipeReset2};
      if (expQ2.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL small_write: got unexpected write addr %0d data %h, required no write", imemAddr2, imemData2);
      end else begin
        exp2 = expQ2.pop_front();
        if (got2 !== exp2) begin
          miscompares++;
          $display("[TB] FAIL small_write: got addr %0d data %h pipe_reset %b, required addr %0d data %h pipe_reset %b",
                   got2.addr, got2.data, got2.isLast, exp2.addr, exp2.data, exp2.isLast);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    vectors++;
    if ({state1, imemWe1, pipeReset1, pcEnable1, pipeEnable1, injectNop1, halted1, loadReady1} !== 10'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, required 0", {state1, imemWe1, pipeReset1, pcEnable1, pipeEnable1, injectNop1, halted1, loadReady1});
    end
    vectors++;
    if ({cycleCount1, imemAddr1} !== 42'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_count_addr: got count %0d addr %0d, required 0 0", cycleCount1, imemAddr1);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load_three();
    cmdValid = 1'b1; cmd = CMD_LOAD;
    @(negedge clock);
    cmdValid = 1'b0;
    #1;
    vectors++;
    if ({state1, loadReady1, cmdReady1} !== {S_LOAD, 2'b10}) begin
      miscompares++;
      $display("[TB] FAIL load_entry: got state %0d ready %b cmd_ready %b, required 1 1 0", state1, loadReady1, cmdReady1);
    end
    for (int i = 0; i < 3; i++) begin
      loadValid = 1'b1; loadData = 32'hA000_00A0 + 32'(i); loadLast = (i == 2);
      expQ1.push_back('{addr: 10'(i), data: loadData, isLast: (i == 2)});
      @(negedge clock);
    end
    loadValid = 1'b0; loadLast = 1'b0;
    #1;
    vectors++;
    if (state1 !== S_IDLE) begin
      miscompares++;
      $display("[TB] FAIL load3_state: got %0d, required %0d", state1, S_IDLE);
    end
    @(negedge clock);
    #1;
    vectors++;
    if ({pipeReset1, imemWe1} !== 2'b00 || expQ1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL load3_done: got pipe_reset %b we %b pending %0d, required 0 0 0", pipeReset1, imemWe1, expQ1.size());
    end
  endtask

  task automatic test_load_depth();
    cmdValid2 = 1'b1; cmd = CMD_LOAD;
    @(negedge clock);
    cmdValid2 = 1'b0; cmd = CMD_NOP;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (loadReady2 !== (i < 4)) begin
        miscompares++;
        $display("[TB] FAIL depth_ready beat %0d: got %b, required %b", i, loadReady2, (i < 4));
      end
      loadValid2 = 1'b1; loadData = 32'hB000_0000 + 32'(i); loadLast2 = 1'b0;
      if (i < 4) expQ2.push_back('{addr: 10'(i), data: loadData, isLast: (i == 3)});
      @(negedge clock);
    end
    loadValid2 = 1'b0;
    #1;
    vectors++;
    if (state2 !== S_IDLE || expQ2.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL depth_done: got state %0d pending %0d, required 0 0", state2, expQ2.size());
    end
  endtask

  task automatic test_run_halt();
    instruction = '0; cmdValid = 1'b1; cmd = CMD_RUN;
    @(negedge clock);
    cmdValid = 1'b0; cmd = CMD_NOP;
    for (int i = 0; i < 7; i++) begin
      #1;
      vectors++;
      if ({state1, pcEnable1, pipeEnable1, injectNop1} !== {S_RUN, 3'b110}) begin
        miscompares++;
        $display("[TB] FAIL run_cycle %0d: got state %0d pc/pipe/nop %b, required 2 110", i, state1, {pcEnable1, pipeEnable1, injectNop1});
      end
      @(negedge clock);
    end
    instruction = HALT;
    #1;
    vectors++;
    if ({pcEnable1, pipeEnable1, injectNop1} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL halt_cycle: got pc/pipe/nop %b, required 011", {pcEnable1, pipeEnable1, injectNop1});
    end
    @(negedge clock);
    instruction = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({state1, pcEnable1, pipeEnable1, injectNop1} !== {S_DRAIN, 3'b011}) begin
        miscompares++;
        $display("[TB] FAIL drain_cycle %0d: got state %0d pc/pipe/nop %b, required 5 011", i, state1, {pcEnable1, pipeEnable1, injectNop1});
      end
      @(negedge clock);
    end
    #1;
    vectors++;
    if ({state1, halted1, pipeEnable1} !== {S_HALTED, 2'b10}) begin
      miscompares++;
      $display("[TB] FAIL halted_state: got state %0d halted %b pipe %b, required 6 1 0", state1, halted1, pipeEnable1);
    end
    vectors++;
    if (cycleCount1 !== 32'd13) begin
      miscompares++;
      $display("[TB] FAIL run_count: got %0d, required 13", cycleCount1);
    end
  endtask

  task automatic test_step();
    cmdValid = 1'b1; cmd = CMD_RESTART;
    @(negedge clock);
    cmd = CMD_RUN;
    @(negedge clock);
    cmd = CMD_PAUSE;
    @(negedge clock);
    cmdValid = 1'b0;
    #1;
    vectors++;
    if (state1 !== S_PAUSED || cycleCount1 !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL pause_entry: got state %0d count %0d, required 4 1", state1, cycleCount1);
    end
    for (int s = 0; s < 3; s++) begin
      cmdValid = 1'b1; cmd = CMD_STEP; stall = (s == 1);
      @(negedge clock);
      cmdValid = 1'b0;
      #1;
      vectors++;
      if ({state1, pcEnable1, pipeEnable1} !== {S_STEP, (s != 1), 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL step %0d: got state %0d pc %b pipe %b, required 3 %b 1", s, state1, pcEnable1, pipeEnable1, (s != 1));
      end
      @(negedge clock);
      stall = 1'b0;
      #1;
      vectors++;
      if (state1 !== S_PAUSED) begin
        miscompares++;
        $display("[TB] FAIL step_exit %0d: got state %0d, required 4", s, state1);
      end
    end
    vectors++;
    if (cycleCount1 !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL step_count: got %0d, required 4", cycleCount1);
    end
  endtask

  task automatic test_pause_halt();
    cmdValid = 1'b1; cmd = CMD_RUN;
    @(negedge clock);
    cmd = CMD_PAUSE; instruction = HALT;
    #1;
    vectors++;
    if ({pcEnable1, injectNop1} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL pause_halt_comb: got pc/nop %b, required 01", {pcEnable1, injectNop1});
    end
    @(negedge clock);
    cmdValid = 1'b0; instruction = '0;
    #1;
    vectors++;
    if (state1 !== S_DRAIN) begin
      miscompares++;
      $display("[TB] FAIL pause_halt_state: got %0d, required 5", state1);
    end
    repeat (5) @(negedge clock);
    #1;
    vectors++;
    if (state1 !== S_HALTED || cycleCount1 !== 32'd10) begin
      miscompares++;
      $display("[TB] FAIL pause_halt_end: got state %0d count %0d, required 6 10", state1, cycleCount1);
    end
    cmdValid = 1'b1; cmd = CMD_RUN;
    @(negedge clock);
    cmdValid = 1'b0;
    #1;
    vectors++;
    if (state1 !== S_HALTED || pcEnable1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL halted_run: got state %0d pc %b, required 6 0", state1, pcEnable1);
    end
    cmdValid = 1'b1; cmd = CMD_RESTART;
    @(negedge clock);
    cmdValid = 1'b0;
    #1;
    vectors++;
    if ({pipeReset1, state1} !== {1'b1, S_IDLE} || cycleCount1 !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL restart: got pipe_reset %b state %0d count %0d, required 1 0 0", pipeReset1, state1, cycleCount1);
    end
    @(negedge clock);
    #1;
    vectors++;
    if (pipeReset1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_pulse: got %b, required 0", pipeReset1);
    end
  endtask

  task automatic test_reset_midload();
    cmdValid = 1'b1; cmd = CMD_LOAD;
    @(negedge clock);
    cmdValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      loadValid = 1'b1; loadData = 32'hC000_0000 + 32'(i); loadLast = 1'b0;
      expQ1.push_back('{addr: 10'(i), data: loadData, isLast: 1'b0});
      @(negedge clock);
    end
    reset = 1'b1; loadData = 32'hC000_0002;
    @(negedge clock);
    #1;
    vectors++;
    if ({state1, imemWe1} !== {S_IDLE, 1'b0} || imemAddr1 !== 10'd0 || expQ1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midload_reset: got state %0d we %b addr %0d pending %0d, required 0 0 0 0",
               state1, imemWe1, imemAddr1, expQ1.size());
    end
    reset = 1'b0; loadValid = 1'b0;
    cmdValid = 1'b1; cmd = CMD_LOAD;
    @(negedge clock);
    cmdValid = 1'b0;
    loadValid = 1'b1; loadLast = 1'b1; loadData = 32'hD000_0000;
    expQ1.push_back('{addr: 10'd0, data: loadData, isLast: 1'b1});
    @(negedge clock);
    loadValid = 1'b0; loadLast = 1'b0;
    @(negedge clock);
    #1;
    vectors++;
    if (state1 !== S_IDLE || expQ1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reload_after_reset: got state %0d pending %0d, required 0 0", state1, expQ1.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_three();
    test_load_depth();
    test_run_halt();
    test_step();
    test_pause_halt();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
